mem_arbiter: RTL and testbench



---
 rtl/wisc_mem_pkg.sv | 20 ++
 rtl/mem_lat_cnt.sv | 34 +++
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_mem_pkg.sv
// Shared types and defaults for the WISC-15 unified-memory arbiter.
// Optional statistics counters in mem_arbiter are enabled by defining MEM_ARB_STATS_EN.
package wisc_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_D = 2'd1,
    ARB_BUSY_I = 2'd2
  } arb_state_t;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned STAT_W     = 16;

  // Counter width for a given latency; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter tracking the remaining cycles of a memory access.
// Saturates at zero and exposes a zero flag marking the last access cycle.
module mem_lat_cnt
  import wisc_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = cnt_width(MEM_LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  // The grant cycle already consumes the first count of the MEM_LAT-1 loaded
  // at grant, so the register lands one lower and hits zero in the last cycle.
  localparam int unsigned LOAD_V = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_V);
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM data access, data first.
// Define MEM_ARB_STATS_EN to add the stat_if_stall / stat_conflict counters.
module mem_arbiter
  import wisc_mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_if_stall,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  arb_state_t r_state;

  logic w_dm_req;
  logic w_idle;
  logic w_sel_d;
  logic w_sel_i;
  logic w_dv;
  logic w_iv;
  logic w_last;
  logic w_cnt_zero;
  logic w_cnt_load;
  logic w_cnt_dec;

  assign w_dm_req = dm_rd | dm_wr;
  assign w_idle   = (r_state == ARB_IDLE);

  // In IDLE the grant is decided combinationally, making that cycle access cycle 1.
  assign w_sel_d = w_idle ? w_dm_req            : (r_state == ARB_BUSY_D);
  assign w_sel_i = w_idle ? (!w_dm_req && if_req) : (r_state == ARB_BUSY_I);

  // A granted side that drops its request aborts: no strobe, no ready.
  assign w_dv = !rst && w_sel_d && w_dm_req;
  assign w_iv = !rst && w_sel_i && if_req;

  assign w_last     = w_idle ? (MEM_LAT == 1) : w_cnt_zero;
  assign w_cnt_load = w_idle && (w_dv || w_iv);
  assign w_cnt_dec  = !w_idle;

  mem_lat_cnt #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_dec  (w_cnt_dec),
    .o_zero (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (MEM_LAT > 1) begin
            if (w_dm_req) begin
              r_state <= ARB_BUSY_D;
            end else if (if_req) begin
              r_state <= ARB_BUSY_I;
            end
          end
        end
        ARB_BUSY_D: begin
          if (!w_dm_req || w_cnt_zero) begin
            r_state <= ARB_IDLE;
          end
        end
        ARB_BUSY_I: begin
          if (!if_req || w_cnt_zero) begin
            r_state <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = w_dv || w_iv;
    mem_we    = w_dv && dm_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_dv) begin
      mem_addr = dm_addr;
      if (dm_wr) begin
        mem_wdata = dm_wdata;
      end
    end else if (w_iv) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    dm_ready = w_dv && w_last;
    if_ready = w_iv && w_last;
    dm_rdata = (dm_ready && !dm_wr) ? mem_rdata : '0;
    if_rdata = if_ready ? mem_rdata : '0;
  end

  assign stall_if  = !rst && if_req   && !if_ready;
  assign stall_mem = !rst && w_dm_req && !dm_ready;

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_if_stall;
  logic [STAT_W-1:0] r_stat_conflict;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_if_stall <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (stall_if && (r_stat_if_stall != '1)) begin
        r_stat_if_stall <= r_stat_if_stall + STAT_W'(1);
      end
      if (w_idle && w_dm_req && if_req && (r_stat_conflict != '1)) begin
        r_stat_conflict <= r_stat_conflict + STAT_W'(1);
      end
    end
  end

  assign stat_if_stall = rst ? '0 : r_stat_if_stall;
  assign stat_conflict = rst ? '0 : r_stat_conflict;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
// Stats checks are included when MEM_ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] exp_if[$];
  logic [15:0] exp_dm[$];
  logic [15:0] exp_if1[$];
  logic [15:0] exp_dm1[$];

  // DUT with MEM_LAT=2
  logic        if_req, if_ready, dm_rd, dm_wr, dm_ready, mem_en, mem_we, stall_if, stall_mem;
  logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  // DUT with MEM_LAT=1
  logic        if_req1, if_ready1, dm_rd1, dm_wr1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1;
  logic [15:0] if_addr1, if_rdata1, dm_addr1, dm_wdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] stat_if_stall, stat_conflict, stat_if_stall1, stat_conflict1;
`endif

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0010: return 16'hA5A5;
      16'h0020: return 16'h1357;
      16'h0030: return 16'hBEEF;
      16'h0040: return 16'h7777;
      16'h0050: return 16'h6666;
      default:  return 16'hDEAD;
    endcase
  endfunction

  assign mem_rdata  = mem_model(mem_addr);
  assign mem_rdata1 = mem_model(mem_addr1);

  mem_arbiter #(.MEM_LAT(2), .ADDR_W(16), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_stall(stat_if_stall), .stat_conflict(stat_conflict)
`endif
  );

  mem_arbiter #(.MEM_LAT(1), .ADDR_W(16), .DATA_W(16)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
    .dm_rd(dm_rd1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
`ifdef MEM_ARB_STATS_EN
    , .stat_if_stall(stat_if_stall1), .stat_conflict(stat_conflict1)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops expected read data whenever a ready strobe is presented.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (if_ready) begin
        if (exp_if.size() == 0) chk("if_ready_unexpected", 32'd1, 32'd0);
        else begin e = exp_if.pop_front(); chk("if_rdata", 32'(if_rdata), 32'(e)); end
      end
      if (dm_ready) begin
        if (exp_dm.size() == 0) chk("dm_ready_unexpected", 32'd1, 32'd0);
        else begin e = exp_dm.pop_front(); chk("dm_rdata", 32'(dm_rdata), 32'(e)); end
      end
      if (if_ready1) begin
        if (exp_if1.size() == 0) chk("if_ready1_unexpected", 32'd1, 32'd0);
        else begin e = exp_if1.pop_front(); chk("if_rdata1", 32'(if_rdata1), 32'(e)); end
      end
      if (dm_ready1) begin
        if (exp_dm1.size() == 0) chk("dm_ready1_unexpected", 32'd1, 32'd0);
        else begin e = exp_dm1.pop_front(); chk("dm_rdata1", 32'(dm_rdata1), 32'(e)); end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_req = 0; if_addr = '0; dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    if_req1 = 0; if_addr1 = '0; dm_rd1 = 0; dm_wr1 = 0; dm_addr1 = '0; dm_wdata1 = '0;
  endtask

  typedef struct {
    logic        rd;
    logic [15:0] daddr;
    logic        ireq;
    logic [15:0] iaddr;
    logic        exp_dmr;
    logic        exp_ifr;
    logic        exp_sif;
  } l1_vec_t;

  l1_vec_t l1_tab[4];

  initial begin
    idle_all();
    rst = 1;
    if_req = 1; dm_rd = 1; dm_addr = 16'h0030; if_addr = 16'h0010;
    @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_stall_if", 32'(stall_if), 0);
    chk("rst_stall_mem", 32'(stall_mem), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    step(); step();
    rst = 0; idle_all();
    @(negedge clk);
    chk("idle_mem_en", 32'(mem_en), 0);

    // Uncontended fetch
    step();
    if_req = 1; if_addr = 16'h0010; exp_if.push_back(16'hA5A5);
    @(negedge clk);
    chk("f_c1_stall_if", 32'(stall_if), 1);
    chk("f_c1_if_ready", 32'(if_ready), 0);
    chk("f_c1_mem_en", 32'(mem_en), 1);
    chk("f_c1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f_c1_mem_we", 32'(mem_we), 0);
    step();
    @(negedge clk);
    chk("f_c2_if_ready", 32'(if_ready), 1);
    chk("f_c2_stall_if", 32'(stall_if), 0);
    step(); if_req = 0;
    @(negedge clk);
    chk("f_after_mem_en", 32'(mem_en), 0);

    // Simultaneous fetch and load: data first, fetch follows without bubble
    step();
    if_req = 1; if_addr = 16'h0020; dm_rd = 1; dm_addr = 16'h0030;
    exp_dm.push_back(16'hBEEF); exp_if.push_back(16'h1357);
    @(negedge clk);
    chk("c_c1_mem_addr", 32'(mem_addr), 32'h0030);
    chk("c_c1_stall_mem", 32'(stall_mem), 1);
    chk("c_c1_stall_if", 32'(stall_if), 1);
    step();
    @(negedge clk);
    chk("c_c2_dm_ready", 32'(dm_ready), 1);
    chk("c_c2_if_ready", 32'(if_ready), 0);
    chk("c_c2_stall_mem", 32'(stall_mem), 0);
    step(); dm_rd = 0;
    @(negedge clk);
    chk("c_c3_mem_addr", 32'(mem_addr), 32'h0020);
    chk("c_c3_if_ready", 32'(if_ready), 0);
    step();
    @(negedge clk);
    chk("c_c4_if_ready", 32'(if_ready), 1);
    step(); if_req = 0;
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflict", 32'(stat_conflict), 1);
    chk("stat_if_stall", 32'(stat_if_stall), 4);
`endif

    // Store: command held for both cycles, read data forced to zero
    step();
    dm_wr = 1; dm_addr = 16'h0040; dm_wdata = 16'h1234; exp_dm.push_back(16'h0000);
    for (int unsigned c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("w_mem_we", 32'(mem_we), 1);
      chk("w_mem_addr", 32'(mem_addr), 32'h0040);
      chk("w_mem_wdata", 32'(mem_wdata), 32'h1234);
      chk("w_dm_ready", 32'(dm_ready), (c == 2) ? 1 : 0);
      step();
    end
    // Read and write together behaves as a write
    dm_rd = 1; dm_wr = 1; dm_addr = 16'h0050; dm_wdata = 16'h9999; exp_dm.push_back(16'h0000);
    @(negedge clk);
    chk("rw_mem_we", 32'(mem_we), 1);
    chk("rw_mem_wdata", 32'(mem_wdata), 32'h9999);
    step(); step();
    idle_all();

    // Fetch dropped in its second cycle: aborts, pending load granted next
    step();
    if_req = 1; if_addr = 16'h0010;
    @(negedge clk);
    chk("a_c1_mem_addr", 32'(mem_addr), 32'h0010);
    step();
    if_req = 0; dm_rd = 1; dm_addr = 16'h0030; exp_dm.push_back(16'hBEEF);
    @(negedge clk);
    chk("a_c2_if_ready", 32'(if_ready), 0);
    chk("a_c2_mem_en", 32'(mem_en), 0);
    chk("a_c2_stall_mem", 32'(stall_mem), 1);
    step();
    @(negedge clk);
    chk("a_c3_mem_en", 32'(mem_en), 1);
    chk("a_c3_mem_addr", 32'(mem_addr), 32'h0030);
    chk("a_c3_dm_ready", 32'(dm_ready), 0);
    step();
    @(negedge clk);
    chk("a_c4_dm_ready", 32'(dm_ready), 1);
    step(); idle_all();

    // Reset in the middle of a load
    step();
    dm_rd = 1; dm_addr = 16'h0030;
    @(negedge clk);
    chk("r_c1_mem_en", 32'(mem_en), 1);
    step();
    rst = 1;
    @(negedge clk);
    chk("r_mem_en", 32'(mem_en), 0);
    chk("r_dm_ready", 32'(dm_ready), 0);
    chk("r_stall_mem", 32'(stall_mem), 0);
    chk("r_mem_addr", 32'(mem_addr), 0);
    step();
    rst = 0; dm_addr = 16'h0020; exp_dm.push_back(16'h1357);
    @(negedge clk);
    chk("r_new_c1_dm_ready", 32'(dm_ready), 0);
    step();
    @(negedge clk);
    chk("r_new_c2_dm_ready", 32'(dm_ready), 1);
    step(); idle_all();
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    chk("stat_conflict_clr", 32'(stat_conflict), 0);
    chk("stat_if_stall_clr", 32'(stat_if_stall), 0);
`endif

    // MEM_LAT=1: back-to-back loads complete every cycle
    l1_tab[0] = '{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    l1_tab[1] = '{1'b1, 16'h0020, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    l1_tab[2] = '{1'b1, 16'h0030, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b1};
    l1_tab[3] = '{1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0};
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      dm_rd1 = l1_tab[i].rd; dm_addr1 = l1_tab[i].daddr;
      if_req1 = l1_tab[i].ireq; if_addr1 = l1_tab[i].iaddr;
      if (l1_tab[i].exp_dmr) exp_dm1.push_back(mem_model(l1_tab[i].daddr));
      if (l1_tab[i].exp_ifr) exp_if1.push_back(mem_model(l1_tab[i].iaddr));
      @(negedge clk);
      chk("l1_dm_ready", 32'(dm_ready1), 32'(l1_tab[i].exp_dmr));
      chk("l1_if_ready", 32'(if_ready1), 32'(l1_tab[i].exp_ifr));
      chk("l1_stall_mem", 32'(stall_mem1), 0);
      chk("l1_stall_if", 32'(stall_if1), 32'(l1_tab[i].exp_sif));
      step();
    end
    idle_all();
    step(); step();

    chk("q_if_empty", 32'(exp_if.size()), 0);
    chk("q_dm_empty", 32'(exp_dm.size()), 0);
    chk("q_if1_empty", 32'(exp_if1.size()), 0);
    chk("q_dm1_empty", 32'(exp_dm1.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
